// File: rtl/sysid_timer_slave.sv
// sysid_timer_slave
//   Avalon-MM system-ID / uptime slave. Exposes a fixed ID and build
//   timestamp, a free-running uptime counter with an atomic 64-bit read
//   path (UPT_LO read latches the high part into a shadow), a CTRL/status
//   register and a bank of read/write scratch registers.
//
// Ports
//   clock          system clock, rising edge
//   reset_n        synchronous active-low reset
//   address[3:0]   word address
//   read, write    single-cycle access strobes
//   writedata[31:0]
//   readdata[31:0] registered read data, held while readdatavalid = 0
//   readdatavalid  one-cycle pulse per accepted read
//
// Read pipeline: the edge that samples `read` also captures the pre-write
// register value (so read/write collisions return old data, and the UPT_LO
// sample and shadow load happen together). The next edge presents it on
// readdata, which lets a reset in the intervening cycle drop the read.
module sysid_timer_slave #(
  parameter logic [31:0] ID_VALUE     = 32'h6685_0E03,
  parameter logic [31:0] TIMESTAMP    = 32'h0,
  parameter int          UPTIME_WIDTH = 64,
  parameter int          NUM_SCRATCH  = 4
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [3:0]  address,
  input  logic        read,
  input  logic        write,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        readdatavalid
);

  localparam logic [3:0] A_ID   = 4'd0;
  localparam logic [3:0] A_TS   = 4'd1;
  localparam logic [3:0] A_UPLO = 4'd2;
  localparam logic [3:0] A_UPHI = 4'd3;
  localparam logic [3:0] A_CTRL = 4'd4;

  logic [UPTIME_WIDTH-1:0]       uptime;
  logic [31:0]                   shadow;
  logic                          freeze;
  logic                          wrap;
  logic [NUM_SCRATCH-1:0][31:0]  scratch;

  logic [31:0] rd_mux;
  logic [31:0] rd_q;
  logic [1:0]  vld_pipe;   // [0]: read captured, [1]: read presented

  logic ctrl_wr, clr, inc, wrap_now;

  assign ctrl_wr  = write && (address == A_CTRL);
  assign clr      = ctrl_wr && writedata[0];
  assign inc      = !clr && !freeze;
  // Wrap is flagged only when the counter actually steps past all-ones.
  assign wrap_now = inc && (&uptime);

  // Pre-write view of the addressed register.
  always_comb begin
    rd_mux = 32'h0;
    case (address)
      A_ID:   rd_mux = ID_VALUE;
      A_TS:   rd_mux = TIMESTAMP;
      A_UPLO: rd_mux = uptime[31:0];
      A_UPHI: rd_mux = shadow;
      A_CTRL: rd_mux = {29'h0, wrap, freeze, 1'b0};
      default: begin
        if (address[3] && (int'(address[2:0]) < NUM_SCRATCH))
          rd_mux = scratch[address[2:0]];
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      uptime        <= '0;
      shadow        <= '0;
      freeze        <= 1'b0;
      wrap          <= 1'b0;
      scratch       <= '0;
      rd_q          <= '0;
      vld_pipe      <= '0;
      readdata      <= '0;
      readdatavalid <= 1'b0;
    end else begin
      // Counter: clear > freeze > increment.
      if (clr)      uptime <= '0;
      else if (inc) uptime <= uptime + UPTIME_WIDTH'(1);

      if (ctrl_wr) freeze <= writedata[1];

      // Set-on-wrap wins over write-1-to-clear.
      if (wrap_now)                      wrap <= 1'b1;
      else if (ctrl_wr && writedata[2])  wrap <= 1'b0;

      if (read && (address == A_UPLO))
        shadow <= 32'(uptime[UPTIME_WIDTH-1:32]);

      for (int i = 0; i < NUM_SCRATCH; i++)
        if (write && (address == 4'(8 + i)))
          scratch[i] <= writedata;

      vld_pipe[0] <= read;
      if (read) rd_q <= rd_mux;
      vld_pipe[1] <= vld_pipe[0];

      if (vld_pipe[0]) readdata <= rd_q;
      readdatavalid <= vld_pipe[0];
    end
  end

endmodule

// File: tb/tb_sysid_timer_slave.sv
// Bench for sysid_timer_slave (UPTIME_WIDTH = 33 so the wrap is reachable).
// Reads push expected data to a scoreboard; a negedge monitor pops and
// compares whenever readdatavalid is seen, and also checks read latency.
// Long counter runs are replaced by preloading the counter in simulation.
module tb_sysid_timer_slave;

  localparam logic [31:0] ID  = 32'h6685_0E03;
  localparam logic [31:0] TS  = 32'h2024_0611;
  localparam int          UW  = 33;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic [3:0]  address = '0;
  logic        read = 1'b0;
  logic        write = 1'b0;
  logic [31:0] writedata = '0;
  logic [31:0] readdata;
  logic        readdatavalid;

  sysid_timer_slave #(
    .ID_VALUE(ID), .TIMESTAMP(TS), .UPTIME_WIDTH(UW), .NUM_SCRATCH(4)
  ) dut (
    .clock(clock), .reset_n(reset_n), .address(address), .read(read),
    .write(write), .writedata(writedata), .readdata(readdata),
    .readdatavalid(readdatavalid)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] val;
    bit          chk;
    int          cyc;
    logic [3:0]  addr;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  logic [31:0] last_data = '0;

  always @(posedge clock) cyc++;

  // Scoreboard monitor.
  always @(negedge clock) begin
    if (readdatavalid) begin
      checks++;
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL spurious_valid: readdatavalid=1 with no read pending");
      end else begin
        exp_t e;
        e = sb.pop_front();
        last_data = readdata;
        if (cyc - e.cyc !== 2) begin
          failures++;
          $display("FAIL latency addr=%0d: got %0d cycles, want 2", e.addr, cyc - e.cyc);
        end
        if (e.chk) begin
          checks++;
          if (readdata !== e.val) begin
            failures++;
            $display("FAIL read addr=%0d: got %h, want %h", e.addr, readdata, e.val);
          end
        end
      end
    end
  end

  // All issue tasks start and end on a negedge.
  task automatic issue_rd(input logic [3:0] a, input logic [31:0] v, input bit chk = 1);
    exp_t e;
    address = a; read = 1'b1; write = 1'b0;
    e.val = v; e.chk = chk; e.cyc = cyc; e.addr = a;
    sb.push_back(e);
    @(negedge clock);
  endtask

  task automatic issue_wr(input logic [3:0] a, input logic [31:0] d);
    address = a; read = 1'b0; write = 1'b1; writedata = d;
    @(negedge clock);
  endtask

  task automatic issue_rw(input logic [3:0] a, input logic [31:0] d, input logic [31:0] v);
    exp_t e;
    address = a; read = 1'b1; write = 1'b1; writedata = d;
    e.val = v; e.chk = 1; e.cyc = cyc; e.addr = a;
    sb.push_back(e);
    @(negedge clock);
  endtask

  task automatic idle();
    read = 1'b0; write = 1'b0;
    @(negedge clock);
  endtask

  task automatic flush();
    read = 1'b0; write = 1'b0;
    for (int i = 0; i < 20 && sb.size() != 0; i++) @(negedge clock);
    if (sb.size() != 0) begin
      checks++; failures++;
      $display("FAIL flush_timeout: %0d reads never returned", sb.size());
      sb.delete();
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(negedge clock);
    checks++;
    if (readdatavalid !== 1'b0 || readdata !== 32'h0) begin
      failures++;
      $display("FAIL reset_outputs: valid=%b data=%h, want 0/0", readdatavalid, readdata);
    end
    reset_n = 1'b1;
    // Back-to-back reads.
    issue_rd(4'd0, ID);
    issue_rd(4'd1, TS);
    issue_rd(4'd4, 32'h0);
    issue_rd(4'd15, 32'h0);
    flush();
  endtask

  task automatic test_atomic();
    // Counter preloaded to 0x1_FFFF_FFFF during the UPT_LO request cycle.
    address = 4'd2; read = 1'b1; write = 1'b0;
    begin
      exp_t e;
      e.val = 32'hFFFF_FFFF; e.chk = 1; e.cyc = cyc; e.addr = 4'd2;
      sb.push_back(e);
    end
    force dut.uptime = 33'h1_FFFF_FFFF;
    #1 release dut.uptime;
    @(negedge clock);
    idle(); idle();
    issue_rd(4'd3, 32'h0000_0001);   // shadow, live high part is now 0
    issue_rd(4'd4, 32'h4);           // that roll-over wrapped 33 bits
    flush();
  endtask

  task automatic test_wrap();
    issue_wr(4'd4, 32'h4);
    issue_rd(4'd4, 32'h0);
    flush();
    // Natural wrap.
    force dut.uptime = {UW{1'b1}};
    #1 release dut.uptime;
    @(negedge clock);
    issue_rd(4'd2, 32'h0);
    issue_rd(4'd4, 32'h4);
    issue_wr(4'd4, 32'h4);
    issue_rd(4'd4, 32'h0);
    flush();
    // Wrap and W1C in the same cycle: set wins.
    address = 4'd4; write = 1'b1; read = 1'b0; writedata = 32'h4;
    force dut.uptime = {UW{1'b1}};
    #1 release dut.uptime;
    @(negedge clock);
    issue_rd(4'd4, 32'h4);
    issue_wr(4'd4, 32'h4);
    flush();
  endtask

  task automatic test_freeze_clear();
    logic [31:0] v1, v2;
    issue_wr(4'd4, 32'h2);
    issue_rd(4'd2, 32'h0, 0);
    flush();
    v1 = last_data;
    repeat (10) @(negedge clock);
    issue_rd(4'd2, 32'h0, 0);
    flush();
    v2 = last_data;
    checks++;
    if (v1 !== v2) begin
      failures++;
      $display("FAIL freeze_hold: second read %h, want %h", v2, v1);
    end
    issue_rd(4'd4, 32'h2);
    issue_wr(4'd4, 32'h3);
    idle();
    issue_rd(4'd2, 32'h0);
    issue_rd(4'd4, 32'h2);
    issue_wr(4'd4, 32'h0);
    idle(); idle();
    issue_rd(4'd2, 32'h2);   // resumed: two increments after unfreeze
    flush();
  endtask

  task automatic test_scratch();
    for (int n = 0; n < 4; n++) issue_wr(4'(8 + n), 32'hA5A5_0000 + n);
    for (int n = 0; n < 4; n++) issue_rd(4'(8 + n), 32'hA5A5_0000 + n);
    issue_wr(4'd12, 32'hDEAD_BEEF);
    issue_rd(4'd12, 32'h0);
    issue_rw(4'd8, 32'h1234_5678, 32'hA5A5_0000);
    issue_rd(4'd8, 32'h1234_5678);
    flush();
  endtask

  task automatic test_reset_mid_read();
    address = 4'd8; read = 1'b1; write = 1'b0;   // dropped read
    @(negedge clock);
    read = 1'b0; reset_n = 1'b0;
    @(negedge clock);
    checks++;
    if (readdatavalid !== 1'b0 || readdata !== 32'h0) begin
      failures++;
      $display("FAIL reset_mid_read: valid=%b data=%h, want 0/0", readdatavalid, readdata);
    end
    reset_n = 1'b1;
    issue_rd(4'd2, 32'h0);
    issue_rd(4'd8, 32'h0);
    issue_rd(4'd4, 32'h0);
    flush();
  endtask

  initial begin
    @(negedge clock);
    test_reset();
    test_atomic();
    test_wrap();
    test_freeze_clear();
    test_scratch();
    test_reset_mid_read();
    repeat (4) @(negedge clock);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
